// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcode encoding, FSM states and opcode width.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SRL  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_NOR  = 4'b0111,
    OP_NAND = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_JADD = 4'b1010,
    OP_SLT  = 4'b1011,
    OP_SGT  = 4'b1100,
    OP_MUL  = 4'b1101,
    OP_DIVU = 4'b1110,
    OP_REMU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } alu_state_e;

endpackage

// File: rtl/alu_single_cycle.sv
// Combinational half of the ALU: every opcode that completes in the accept cycle.
module alu_single_cycle
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic [N-1:0]        a_i,
  input  logic [N-1:0]        b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [N-1:0]        y_o
);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    y_o = '0;
    case (alu_op_e'(op_i))
      OP_ADD, OP_JADD: y_o = a_i + b_i;
      OP_SUB:          y_o = a_i - b_i;
      OP_SLL:          y_o = a_i << shamt;
      OP_SRL:          y_o = a_i >> shamt;
      OP_AND:          y_o = a_i & b_i;
      OP_OR:           y_o = a_i | b_i;
      OP_XOR:          y_o = a_i ^ b_i;
      OP_NOR:          y_o = ~(a_i | b_i);
      OP_NAND:         y_o = ~(a_i & b_i);
      OP_NOT:          y_o = ~a_i;
      OP_SLT:          y_o = {{(N-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SGT:          y_o = {{(N-1){1'b0}}, ($signed(a_i) > $signed(b_i))};
      default:         y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU with valid/ready handshake, shift-add multiplier and optional
// restoring divider (enabled by defining ALU_ITER_DIV_EN).
module alu_iter
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  input  logic [ALU_OP_W-1:0] op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        result,
  output logic                zero,
  output logic                illegal,
  output logic                busy
);

  localparam int CNT_W = SHW + 1;

  alu_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   result_q;
  logic           out_valid_q, zero_q, illegal_q, busy_q;
  logic           accept;

  alu_state_e     l_state;
  logic [N-1:0]   l_res;
  logic           l_ill;
  logic [N-1:0]   sc_y;

  logic [N:0]     msum;
  logic [2*N-1:0] mul_nxt;
  logic [N-1:0]   fin_res;
  logic           last_iter;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign busy      = busy_q;

  alu_single_cycle #(.N(N), .SHW(SHW)) u_sc (
    .a_i  (a),
    .b_i  (b),
    .op_i (op),
    .y_o  (sc_y)
  );

  // Shift-add: high half accumulates, multiplier shifts out of the low half.
  assign msum    = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_nxt = {msum, acc_q[N-1:1]};
  assign last_iter = (cnt_q == CNT_W'(N - 1));

`ifdef ALU_ITER_DIV_EN
  logic           op_q;
  logic [N:0]     drem, dsub;
  logic           qbit;
  logic [2*N-1:0] div_nxt;

  // Restoring step: remainder in the high half, quotient bits enter at bit 0.
  assign drem    = {acc_q[2*N-1:N], acc_q[N-1]};
  assign dsub    = drem - {1'b0, b_q};
  assign qbit    = ~dsub[N];
  assign div_nxt = {(qbit ? dsub[N-1:0] : drem[N-1:0]), acc_q[N-2:0], qbit};
  assign fin_res = (state_q == DIV) ? (op_q ? div_nxt[2*N-1:N] : div_nxt[N-1:0])
                                    : mul_nxt[N-1:0];
`else
  assign fin_res = mul_nxt[N-1:0];
`endif

  always_comb begin
    l_state = DONE;
    l_res   = sc_y;
    l_ill   = 1'b0;
    case (alu_op_e'(op))
      OP_MUL: l_state = MUL;
      OP_DIVU, OP_REMU: begin
`ifdef ALU_ITER_DIV_EN
        if (b == '0) l_res = (alu_op_e'(op) == OP_DIVU) ? '1 : a;
        else         l_state = DIV;
`else
        l_res = '0;
        l_ill = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      state_q <= l_state;
      cnt_q   <= '0;
      if (l_state == DONE) begin
        out_valid_q <= 1'b1;
        result_q    <= l_res;
        zero_q      <= (l_res == '0);
        illegal_q   <= l_ill;
        busy_q      <= 1'b0;
      end else begin
        out_valid_q <= 1'b0;
        busy_q      <= 1'b1;
      end
    end else begin
      case (state_q)
        MUL, DIV: begin
          if (last_iter) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= fin_res;
            zero_q      <= (fin_res == '0);
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q <= {{N{1'b0}}, a};
      b_q   <= b;
`ifdef ALU_ITER_DIV_EN
      op_q  <= op[0];
`endif
    end else if (state_q == MUL) begin
      acc_q <= mul_nxt;
`ifdef ALU_ITER_DIV_EN
    end else if (state_q == DIV) begin
      acc_q <= div_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: driver pushes model expectations, monitor pops on output handshake.
module tb_alu_iter;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [N-1:0]  a, b;
  logic [3:0]    op;
  logic          out_valid, out_ready;
  logic [N-1:0]  result;
  logic          zero, illegal, busy;

  alu_iter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic         zero;
    logic         ill;
    int           lat;
    int           acc;
    string        nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  bit   seen = 0;
  int   first_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom % 4) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    logic [2*N-1:0] p;
    e.lat = 1;
    e.ill = 1'b0;
    e.res = '0;
    case (o)
      4'd0, 4'd10: e.res = x + y;
      4'd1:  e.res = x - y;
      4'd2:  e.res = x << (y % N);
      4'd3:  e.res = x >> (y % N);
      4'd4:  e.res = x & y;
      4'd5:  e.res = x | y;
      4'd6:  e.res = x ^ y;
      4'd7:  e.res = ~(x | y);
      4'd8:  e.res = ~(x & y);
      4'd9:  e.res = ~x;
      4'd11: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd12: e.res = ($signed(x) > $signed(y)) ? 1 : 0;
      4'd13: begin
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        e.res = p[N-1:0];
        e.lat = N + 1;
      end
      default: begin
`ifdef ALU_ITER_DIV_EN
        if (y == 0) e.res = (o == 4'd14) ? {N{1'b1}} : x;
        else begin
          e.res = (o == 4'd14) ? x / y : x % y;
          e.lat = N + 1;
        end
`else
        e.res = '0;
        e.ill = 1'b1;
`endif
      end
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input string nm);
    exp_t e;
    int   tries = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    #1;
    while (!in_ready && tries < 500) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(o, x, y);
    e.acc = cyc + 1;
    e.nm  = nm;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, q.size(), 0);
  endtask

  // Monitor: sampled mid-low-phase, after out_ready has settled.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid) begin
      if (!seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = q[0];
        chk({e.nm, "_result"}, result, e.res);
        chk({e.nm, "_zero"}, zero, e.zero);
        chk({e.nm, "_illegal"}, illegal, e.ill);
        chk({e.nm, "_busy"}, busy, 0);
        if (!out_ready) chk({e.nm, "_in_ready_stall"}, in_ready, 0);
        else begin
          chk({e.nm, "_latency"}, first_cyc - e.acc + 1, e.lat);
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] ra, rb;
    logic [3:0]   ro;
    logic [N-1:0] edges [4];
    int           n;
    edges[0] = '0; edges[1] = 1; edges[2] = '1; edges[3] = 32'h8000_0000;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    issue(4'd0, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    issue(4'd1, 32'd5, 32'd5, "sub_zero");
    issue(4'd11, 32'hFFFF_FFFF, 32'd1, "slt");
    issue(4'd12, 32'hFFFF_FFFF, 32'd1, "sgt");
    issue(4'd2, 32'd1, 32'h21, "sll_mask");
    wait_drain("single");

    bp_mode = 2;
    issue(4'd13, 32'h0001_0003, 32'd5, "mul_stall");
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mul_wait_timeout", out_valid, 1);
    repeat (3) @(negedge clk);
    bp_mode = 0;
    wait_drain("mul");

    issue(4'd14, 32'd100, 32'd7, "divu");
    issue(4'd15, 32'd100, 32'd7, "remu");
    issue(4'd14, 32'd9, 32'd0, "divu_by0");
    issue(4'd15, 32'd9, 32'd0, "remu_by0");
    wait_drain("div");

    issue(4'd13, 32'h1234_5678, 32'h9ABC_DEF1, "mul_reset");
    repeat (9) @(posedge clk);
    #2;
    chk("busy_mid_mul", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    q.delete();
    seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    issue(4'd0, 32'd2, 32'd3, "add_after_reset");
    wait_drain("reset");

    bp_mode = 1;
    for (int i = 0; i < 80; i++) begin
      ro = 4'($urandom % 16);
      case ($urandom % 4)
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom % 16; rb = $urandom % 16; end
        2: begin ra = $urandom; rb = '0; end
        default: begin ra = edges[$urandom % 4]; rb = edges[$urandom % 4]; end
      endcase
      issue(ro, ra, rb, "rand");
    end
    wait_drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
